// File: rtl/key_press_counter.sv
// key_press_counter
// Turns the debounced, active-low key level from the DE2-115 debouncer into
// press / long-press events and keeps a two-digit BCD press count.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   key_n      in   debounced key level, 0 = pressed
//   press      out  one-cycle pulse per new press
//   long_press out  one-cycle pulse once a press has been held HOLD_CYCLES cycles
//   count_lo   out  BCD ones digit
//   count_hi   out  BCD tens digit
//   wrap       out  one-cycle pulse when the count rolls 99 -> 00
//
// Build option: define LONGPRESS_CLEAR_EN to clear the count on long_press.
module key_press_counter #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned HOLD_W      = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_n,
  output logic       press,
  output logic       long_press,
  output logic [3:0] count_lo,
  output logic [3:0] count_hi,
  output logic       wrap
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] HELD    = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              sync1;
  logic              key_s;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [HOLD_W-1:0] timer;
  logic [HOLD_W-1:0] timer_next;
  logic              press_next;
  logic              long_next;
  logic              wrap_next;
  logic [3:0]        lo_next;
  logic [3:0]        hi_next;

  // Two-flop synchronizer; flops reset to the released level.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= key_n;
      key_s <= sync1;
    end
  end

  // State, timer and all outputs are registered here.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      press      <= 1'b0;
      long_press <= 1'b0;
      wrap       <= 1'b0;
      count_lo   <= 4'd0;
      count_hi   <= 4'd0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      press      <= press_next;
      long_press <= long_next;
      wrap       <= wrap_next;
      count_lo   <= lo_next;
      count_hi   <= hi_next;
    end
  end

  // Next-state, timer and BCD count logic.
  always_comb begin
    state_next = state;
    timer_next = timer;
    press_next = 1'b0;
    long_next  = 1'b0;
    wrap_next  = 1'b0;
    lo_next    = count_lo;
    hi_next    = count_hi;

    case (state)
      IDLE: begin
        if (!key_s) begin
          state_next = PRESSED;
          press_next = 1'b1;
          timer_next = '0;
          if (count_lo == 4'd9) begin
            lo_next = 4'd0;
            if (count_hi == 4'd9) begin
              hi_next   = 4'd0;
              wrap_next = 1'b1;
            end else begin
              hi_next = count_hi + 4'd1;
            end
          end else begin
            lo_next = count_lo + 4'd1;
          end
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (timer == HOLD_LAST) begin
          state_next = HELD;
          long_next  = 1'b1;
`ifdef LONGPRESS_CLEAR_EN
          lo_next    = 4'd0;
          hi_next    = 4'd0;
`else
          lo_next    = count_lo;
          hi_next    = count_hi;
`endif
        end else begin
          timer_next = timer + HOLD_W'(1);
        end
      end
      HELD: begin
        if (key_s) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_press_counter.sv
// Self-checking bench for key_press_counter with HOLD_CYCLES = 16.
module tb_key_press_counter;

  localparam int unsigned HOLD = 16;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic       press;
  logic       long_press;
  logic [3:0] count_lo;
  logic [3:0] count_hi;
  logic       wrap;

  key_press_counter #(.HOLD_CYCLES(HOLD), .HOLD_W(5)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .key_n      (key_n),
    .press      (press),
    .long_press (long_press),
    .count_lo   (count_lo),
    .count_hi   (count_hi),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event statistics gathered by step().
  int cyc = 0;
  int n_press, n_long, n_wrap, n_bad_wrap, n_both, press_cyc, long_cyc;

  typedef struct {
    logic       key;
    logic       press;
    logic       lng;
    logic       wrap;
    logic [3:0] hi;
    logic [3:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_press = 0; n_long = 0; n_wrap = 0; n_bad_wrap = 0; n_both = 0;
    press_cyc = -1; long_cyc = -1;
  endtask

  // Apply key level, advance one edge, sample 1 time unit later.
  task automatic step(input logic k);
    key_n = k;
    @(posedge clk);
    #1;
    cyc++;
    if (press) begin n_press++; press_cyc = cyc; end
    if (long_press) begin n_long++; long_cyc = cyc; end
    if (wrap) n_wrap++;
    if (wrap && !press) n_bad_wrap++;
    if (press && long_press) n_both++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic short_press();
    step(1'b0);
    repeat (3) step(1'b1);
  endtask

  int cnt;

  initial begin
    reset = 1'b1;
    key_n = 1'b1;
    clear_stats();

    // Test 1: reset held 100 cycles with key released.
    repeat (100) step(1'b1);
    check("t1_count", {24'd0, count_hi, count_lo}, 0);
    check("t1_pulses", n_press + n_long + n_wrap, 0);
    @(negedge clk);
    reset = 1'b0;

    // Test 2: 5-cycle press, table-driven per edge; edge k is vecs[0].
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].key);
      check($sformatf("t2_vec%0d", i),
            int'({press, long_press, wrap, count_hi, count_lo}),
            int'({vecs[i].press, vecs[i].lng, vecs[i].wrap, vecs[i].hi, vecs[i].lo}));
    end

    // Test 3: 100 short presses, decade carry and 99 -> 00 wrap.
    do_reset();
    for (int p = 1; p <= 100; p++) begin
      short_press();
      if (p == 10)  check("t3_count10", {24'd0, count_hi, count_lo}, 8'h10);
      if (p == 99)  check("t3_count99", {24'd0, count_hi, count_lo}, 8'h99);
      if (p == 100) check("t3_count100", {24'd0, count_hi, count_lo}, 8'h00);
    end
    check("t3_presses", n_press, 100);
    check("t3_wraps", n_wrap, 1);
    check("t3_wrap_without_press", n_bad_wrap, 0);
    check("t3_long", n_long, 0);

    // Test 4: 40-cycle hold produces one long press 16 edges after press.
    do_reset();
    repeat (40) step(1'b0);
    repeat (4) step(1'b1);
    check("t4_presses", n_press, 1);
    check("t4_longs", n_long, 1);
    check("t4_long_delay", long_cyc - press_cyc, int'(HOLD));
    check("t4_overlap", n_both, 0);
`ifdef LONGPRESS_CLEAR_EN
    check("t4_count", {24'd0, count_hi, count_lo}, 8'h00);
`else
    check("t4_count", {24'd0, count_hi, count_lo}, 8'h01);
`endif
    check("t4_wrap", n_wrap, 0);

    // Test 5: async reset mid-hold, then release with key still held.
    do_reset();
    short_press();
    short_press();
    repeat (5) step(1'b0);
    check("t5_count_before", {24'd0, count_hi, count_lo}, 8'h03);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_async_outputs",
          int'({press, long_press, wrap, count_hi, count_lo}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_stats();
    repeat (10) step(1'b0);
    check("t5_presses", n_press, 1);
    check("t5_count_after", {24'd0, count_hi, count_lo}, 8'h01);

    // Test 6: single-cycle release between two presses.
    do_reset();
    repeat (3) step(1'b0);
    step(1'b1);
    repeat (5) step(1'b0);
    repeat (4) step(1'b1);
    check("t6_presses", n_press, 2);
    cnt = n_long;
    check("t6_longs", cnt, 0);
    check("t6_count", {24'd0, count_hi, count_lo}, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
